// File: rtl/adder_chk_pkg.sv
// adder_chk_pkg: shared FSM states, coverage sizing and first_err field layout
package adder_chk_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cover_points(input int width, input int cin_cover);
    return 1 << (2 * width + cin_cover);
  endfunction
  function automatic int fe_s_lsb(input int width);
    return 0;
  endfunction
  function automatic int fe_cout_bit(input int width);
    return width;
  endfunction
  function automatic int fe_b_lsb(input int width);
    return width + 1;
  endfunction
  function automatic int fe_a_lsb(input int width);
    return 2 * width + 1;
  endfunction
  function automatic int fe_cin_bit(input int width);
    return 3 * width + 1;
  endfunction
endpackage

// File: rtl/adder_ref_model.sv
// adder_ref_model: combinational (WIDTH+1)-bit reference sum a + b + cin
module adder_ref_model #(
  parameter int WIDTH = 4
) (
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);
  assign sum = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
endmodule

// File: rtl/adder_checker.sv
// adder_checker: registered response checker with counters, first-error capture and operand coverage
module adder_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CIN_COVER = 0,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               sample_valid,
  input  logic               cin,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   s,
  input  logic               cout,
  output logic               err_pulse,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   sample_count,
  output logic [2*WIDTH+1:0] cover_count,
  output logic               first_err_valid,
  output logic [3*WIDTH+2:0] first_err,
  output logic               done,
  output logic               pass
);
  localparam int PTS = cover_points(WIDTH, CIN_COVER);
  localparam int IW  = 2 * WIDTH + CIN_COVER;
  localparam int CW  = 2 * WIDTH + 2;
  logic             v1, c1, co1;
  logic [WIDTH-1:0] a1, b1, s1;
  logic [WIDTH:0]   ref_sum;
  logic [2*WIDTH:0] pt;
  logic [IW-1:0]    idx;
  logic [PTS-1:0]   map, map_set;
  logic             mism, fresh;
  logic [CW-1:0]    cov_n;
  logic [CNT_W-1:0] err_n, smp_n;
  state_t           state, state_n;
  adder_ref_model #(.WIDTH(WIDTH)) u_ref (
    .cin(c1),
    .a  (a1),
    .b  (b1),
    .sum(ref_sum)
  );
  // Stage-2 check: mismatch, new coverage point and saturating counter updates
  always_comb begin
    pt      = {c1, a1, b1};
    idx     = pt[IW-1:0];
    mism    = v1 && ({co1, s1} !== ref_sum);
    fresh   = v1 && !map[idx];
    map_set = '0;
    map_set[idx] = fresh;
    cov_n   = cover_count + CW'(fresh);
    err_n   = (mism && err_count != '1) ? err_count + CNT_W'(1) : err_count;
    smp_n   = (v1 && sample_count != '1) ? sample_count + CNT_W'(1) : sample_count;
  end
  // Next state: first checked sample starts RUN, full coverage ends in DONE
  always_comb begin
    state_n = (state == IDLE && v1) ? RUN : state;
    state_n = (state_n == RUN && cov_n == CW'(PTS)) ? DONE : state_n;
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= clear ? IDLE : state_n;
  end
  // Stage-1 capture and all registered checker outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      v1              <= 1'b0;
      c1              <= 1'b0;
      a1              <= '0;
      b1              <= '0;
      s1              <= '0;
      co1             <= 1'b0;
      map             <= '0;
      err_pulse       <= 1'b0;
      err_count       <= '0;
      sample_count    <= '0;
      cover_count     <= '0;
      first_err_valid <= 1'b0;
      first_err       <= '0;
      done            <= 1'b0;
      pass            <= 1'b0;
    end else begin
      v1           <= sample_valid;
      c1           <= cin;
      a1           <= a;
      b1           <= b;
      s1           <= s;
      co1          <= cout;
      map          <= map | map_set;
      err_pulse    <= mism;
      err_count    <= err_n;
      sample_count <= smp_n;
      cover_count  <= cov_n;
      if (mism && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err       <= {c1, a1, b1, co1, s1};
      end
      done <= state_n == DONE;
      pass <= state_n == DONE && err_n == '0;
    end
  end
endmodule

// File: tb/tb_adder_checker.sv
// tb_adder_checker: scoreboard bench driving three checker configurations with shared stimulus
module tb_adder_checker;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, sample_valid = 1'b0, cin = 1'b0, cout = 1'b0;
  logic [3:0] a = '0, b = '0, s = '0;
  logic ep0, fv0, dn0, ps0, ep1, fv1, dn1, ps1, ep2, fv2, dn2, ps2;
  logic [15:0] ec0, sc0, ec1, sc1;
  logic [3:0]  ec2, sc2;
  logic [9:0]  cc0, cc1, cc2;
  logic [14:0] fe0, fe1, fe2;
  logic q[$];
  int n_vec = 0, n_mis = 0, pulses = 0;
  always #5 clk = ~clk;
  adder_checker u0 (.clk(clk), .rst_n(rst_n), .clear(clear), .sample_valid(sample_valid), .cin(cin),
    .a(a), .b(b), .s(s), .cout(cout), .err_pulse(ep0), .err_count(ec0), .sample_count(sc0),
    .cover_count(cc0), .first_err_valid(fv0), .first_err(fe0), .done(dn0), .pass(ps0));
  adder_checker #(.CIN_COVER(1)) u1 (.clk(clk), .rst_n(rst_n), .clear(clear), .sample_valid(sample_valid),
    .cin(cin), .a(a), .b(b), .s(s), .cout(cout), .err_pulse(ep1), .err_count(ec1), .sample_count(sc1),
    .cover_count(cc1), .first_err_valid(fv1), .first_err(fe1), .done(dn1), .pass(ps1));
  adder_checker #(.CNT_W(4)) u2 (.clk(clk), .rst_n(rst_n), .clear(clear), .sample_valid(sample_valid),
    .cin(cin), .a(a), .b(b), .s(s), .cout(cout), .err_pulse(ep2), .err_count(ec2), .sample_count(sc2),
    .cover_count(cc2), .first_err_valid(fv2), .first_err(fe2), .done(dn2), .pass(ps2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic v, input logic ci, input logic [3:0] aa, input logic [3:0] bb,
                      input logic [3:0] ss, input logic co, input logic clr = 1'b0);
    logic [4:0] e;
    e = {1'b0, aa} + {1'b0, bb} + {4'b0, ci};
    @(negedge clk);
    sample_valid = v; cin = ci; a = aa; b = bb; s = ss; cout = co; clear = clr;
    if (clr) q.delete();
    else q.push_back(v && ({co, ss} !== e));
    @(posedge clk);
    #1;
    if (ep0 === 1'b1) pulses++;
    if (q.size() > 1) chk("err_pulse", ep0, q.pop_front());
  endtask
  task automatic good(input logic ci, input logic [3:0] aa, input logic [3:0] bb);
    logic [4:0] e;
    e = {1'b0, aa} + {1'b0, bb} + {4'b0, ci};
    step(1'b1, ci, aa, bb, e[3:0], e[4]);
  endtask
  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
  endtask
  task automatic do_clear();
    step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_pulse"}, ep0, 0);
    chk({tag, "_errc"}, ec0, 0);
    chk({tag, "_smpc"}, sc0, 0);
    chk({tag, "_covc"}, cc0, 0);
    chk({tag, "_fev"}, fv0, 0);
    chk({tag, "_fe"}, fe0, 0);
    chk({tag, "_done"}, dn0, 0);
    chk({tag, "_pass"}, ps0, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      good(1'b0, i[7:4], i[3:0]);
      if (i == 255) chk("sweep_done_early", dn0, 0);
    end
    idle();
    chk("sweep_done", dn0, 1);
    chk("sweep_pass", ps0, 1);
    chk("sweep_smpc", sc0, 256);
    chk("sweep_covc", cc0, 256);
    chk("sweep_errc", ec0, 0);
    chk("cin0_covc", cc1, 256);
    chk("cin0_done", dn1, 0);
    chk("sat_smpc", sc2, 15);
    for (int i = 0; i < 256; i++) begin
      good(1'b1, i[7:4], i[3:0]);
      if (i == 255) begin
        chk("cin1_done_early", dn1, 0);
        chk("cin1_covc_early", cc1, 511);
      end
    end
    idle();
    chk("cin1_done", dn1, 1);
    chk("cin1_pass", ps1, 1);
    chk("cin1_covc", cc1, 512);
    chk("cin1_errc", ec1, 0);
    chk("cin1_u0_covc", cc0, 256);
    chk("cin1_u0_smpc", sc0, 512);
    do_clear();
    chk_zero("clear");
    pulses = 0;
    for (int i = 0; i < 256; i++)
      if (i == 8'h35) step(1'b1, 1'b0, 4'd3, 4'd5, 4'd0, 1'b0);
      else good(1'b0, i[7:4], i[3:0]);
    idle();
    chk("fault_pulses", pulses, 1);
    chk("fault_errc", ec0, 1);
    chk("fault_done", dn0, 1);
    chk("fault_pass", ps0, 0);
    chk("fault_fev", fv0, 1);
    chk("fault_fe", fe0, 15'b0_0011_0101_0_0000);
    do_clear();
    for (int i = 0; i < 100; i++) good(1'b0, i[7:4], i[3:0]);
    step(1'b1, 1'b0, 4'd7, 4'd7, 4'd0, 1'b0, 1'b1);
    chk_zero("midclr");
    idle();
    chk("midclr_smpc", sc0, 0);
    chk("midclr_covc", cc0, 0);
    do_clear();
    repeat (10) good(1'b0, 4'd1, 4'd1);
    idle();
    chk("rep_covc", cc0, 1);
    chk("rep_smpc", sc0, 10);
    chk("rep_errc", ec0, 0);
    do_clear();
    repeat (20) step(1'b1, 1'b0, 4'd1, 4'd1, 4'd0, 1'b0);
    idle();
    chk("sat_errc", ec2, 15);
    chk("sat_u0_errc", ec0, 20);
    repeat (3) idle();
    chk("sat_hold", ec2, 15);
    do_clear();
    step(1'b1, 1'b1, 4'hf, 4'hf, 4'b0x0x, 1'b1);
    idle();
    chk("x_errc", ec0, 1);
    chk("x_fev", fv0, 1);
    do_clear();
    step(1'b1, 1'b0, 4'd3, 4'd5, 4'd0, 1'b0);
    idle();
    chk("rstmid_pulse_pre", ep0, 1);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("rstmid_pulse", ep0, 0);
    chk("rstmid_errc", ec0, 0);
    chk("rstmid_fev", fv0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
